// File: rtl/seg_status_pkg.sv
// Shared types and glyph constants for the status display.
// Segment constants are active-low {g,f,e,d,c,b,a}.
package seg_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COUNTDOWN,
        ST_DEAD
    } state_e;

    // Glyph codes 0..8 are the digits themselves.
    localparam logic [3:0] G_A     = 4'd9;
    localparam logic [3:0] G_C     = 4'd10;
    localparam logic [3:0] G_D     = 4'd11;
    localparam logic [3:0] G_E     = 4'd12;
    localparam logic [3:0] G_DASH  = 4'd13;
    localparam logic [3:0] G_BLANK = 4'd14;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

endpackage

// File: rtl/seg_status_display_glyph_rom.sv
// Combinational glyph code to active-low segment pattern.
module seg_glyph_rom
    import seg_status_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            G_A:     seg = SEG_A;
            G_C:     seg = SEG_C;
            G_D:     seg = SEG_D;
            G_E:     seg = SEG_E;
            G_DASH:  seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_status_display.sv
// Robot life-cycle FSM driving a 4-digit multiplexed common-anode display.
// Define SEG_STATUS_DEAD_BLINK_EN to blink the display while DEAD.
module seg_status_display
    import seg_status_pkg::*;
#(
    parameter int REFRESH_DIV = 12500,
    parameter int BLINK_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cnt_bar,
    input  logic       in_combat,
    input  logic       in_danger,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);

    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink
        $error("BLINK_TICKS must be at least 1");
    end

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    slot_q, slot_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    logic          slot_tick;
    logic [3:0]    secs;
    logic          bar_ok;
    logic [3:0]    code;
    logic [6:0]    glyph_seg;
    logic          lit;

    assign slot_tick = (presc_q == PW'(REFRESH_DIV - 1));

    always_comb begin
        secs = 4'd0;
        for (int i = 0; i < 8; i++) begin
            secs = secs + {3'b000, cnt_bar[i]};
        end
    end

    // A clean thermometer has exactly popcount low ones.
    assign bar_ok = ({1'b0, cnt_bar} == ((9'd1 << secs) - 9'd1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_combat) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!in_combat)     state_d = ST_IDLE;
                else if (in_danger) state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (cnt_bar == 8'h00) state_d = ST_DEAD;
                else if (!in_combat)  state_d = ST_IDLE;
                else if (!in_danger)  state_d = ST_ARMED;
            end
            default: state_d = ST_DEAD;
        endcase
    end

    always_comb begin
        code = G_BLANK;
        case (state_q)
            ST_IDLE: code = G_DASH;
            ST_ARMED, ST_COUNTDOWN: begin
                if (slot_q == 2'd3)      code = (state_q == ST_ARMED) ? G_A : G_C;
                else if (slot_q == 2'd0) code = bar_ok ? secs : G_E;
            end
            default: begin
                case (slot_q)
                    2'd3:    code = G_D;
                    2'd2:    code = G_E;
                    2'd1:    code = G_A;
                    default: code = G_D;
                endcase
            end
        endcase
    end

    seg_glyph_rom u_glyph_rom (
        .code (code),
        .seg  (glyph_seg)
    );

`ifdef SEG_STATUS_DEAD_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Held in reset outside DEAD so every blink sequence opens lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (state_q != ST_DEAD) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (slot_tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign lit = blink_on_q;
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        presc_d = slot_tick ? '0 : presc_q + PW'(1);
        slot_d  = slot_tick ? slot_q + 2'd1 : slot_q;
        seg_d   = glyph_seg;
        an_d    = lit ? ~(4'b0001 << slot_q) : 4'hF;
        dp_d    = !((state_q == ST_COUNTDOWN) && (slot_q == 2'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            slot_q  <= 2'd0;
            seg_q   <= SEG_OFF;
            an_q    <= 4'hF;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            slot_q  <= slot_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule
